delay_scheduler: RTL

//   Shares one prescaled down-counter among N_REQ requesters that each need a timed delay.
//   A round-robin arbiter grants the timer to one requester at a time.
//   The granted requester's delay, in ticks, is latched, counted down, and signalled with a done pulse.

---
 rtl/delay_scheduler.sv | 118 +++++++++++
 1 files changed

// File: rtl/delay_scheduler.sv
// Round-robin shared tick timer: grants one requester, counts its delay in PRESCALE-cycle ticks, pulses done.
// Grant 1 cycle after req is seen, done D*PRESCALE cycles later; owner aborts by dropping req, others wait.
module delay_scheduler #(
  parameter int N_REQ    = 4,
  parameter int DW       = 24,
  parameter int PRESCALE = 27
) (
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] delay,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic [DW-1:0]       remaining
);

  localparam int PTRW = $clog2(N_REQ);
  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [N_REQ-1:0]  grant_nxt;
  logic [PTRW-1:0]   ptr, ptr_nxt;
  logic [DW-1:0]     rem_nxt;
  logic [PW-1:0]     prescaler, pre_nxt;

  logic              win_vld;
  logic [PTRW-1:0]   win_idx;
  logic [PTRW-1:0]   cand;
  logic [DW-1:0]     win_delay;

  // Search starts one past the last winner so a re-requesting owner goes to the back of the line
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PTRW'((int'(ptr) + k) % N_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_delay = delay[int'(win_idx)*DW +: DW];

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    rem_nxt   = remaining;
    pre_nxt   = prescaler;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        rem_nxt   = '0;
        pre_nxt   = '0;
        if (win_vld) begin
          grant_nxt = N_REQ'(1) << win_idx;
          ptr_nxt   = win_idx;
          rem_nxt   = win_delay;
          state_nxt = (win_delay == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!req[ptr]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          rem_nxt   = '0;
          pre_nxt   = '0;
        end else if (prescaler == PW'(PRESCALE - 1)) begin
          pre_nxt = '0;
          rem_nxt = remaining - DW'(1);
          if (remaining == DW'(1)) begin
            state_nxt = DONE;
          end
        end else begin
          pre_nxt = prescaler + PW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        rem_nxt   = '0;
        pre_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        rem_nxt   = '0;
        pre_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= PTRW'(N_REQ - 1);
      remaining <= '0;
      prescaler <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      ptr       <= ptr_nxt;
      remaining <= rem_nxt;
      prescaler <= pre_nxt;
    end
  end

  assign done = (state == DONE) ? grant : '0;
  assign busy = (state != IDLE);

endmodule
